// File: rtl/pkt_stream_gen_pkg.sv
// Shared types and constants for the pkt_stream_gen packet source.
//   state_e     : framing FSM states (gap, header, burst, done)
//   MODE_*      : payload pattern selectors driven on the mode input
//   LFSR_*      : Galois LFSR polynomial (x^32+x^22+x^2+x+1) and per-lane seed base
//   lfsr_next() : one right-shifting Galois LFSR step
package pkt_stream_gen_pkg;

    typedef enum logic [1:0] {
        StGap,
        StHeader,
        StBurst,
        StDone
    } state_e;

    localparam logic [1:0] MODE_RAMP      = 2'd0;
    localparam logic [1:0] MODE_RAMP_CONT = 2'd1;
    localparam logic [1:0] MODE_CONST     = 2'd2;
    localparam logic [1:0] MODE_LFSR      = 2'd3;

    // Tap mask for taps 32, 22, 2, 1 in right-shift Galois form.
    localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_BASE = 32'h0000_0001;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/pkt_stream_gen_lfsr32.sv
// 32-bit Galois LFSR lane used by pkt_stream_gen in LFSR payload mode.
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset, loads seed_i
//   load_i    : reload the register with seed_i (wins over advance_i)
//   seed_i    : seed value
//   advance_i : step the LFSR once
//   value_o   : current LFSR state
module lfsr32
    import pkt_stream_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        advance_i,
    output logic [31:0] value_o
);

    logic [31:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = seed_i;
        end else if (advance_i) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= seed_i;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/pkt_stream_gen.sv
// Framed test-pattern packet source: a header beat followed by burst_len payload beats,
// separated by sleep_write idle cycles, with ready/valid backpressure and a packet limit.
// Optional feature macro: PKT_STREAM_GEN_LFSR_EN builds per-lane LFSRs for mode 3;
// without it, mode 3 produces the per-packet ramp of mode 0.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en            : global advance enable; low freezes all state
//   burst_len     : payload beats per packet (latched at header entry)
//   sleep_write   : idle cycles between packets
//   mode          : payload pattern (ramp, continuous ramp, constant, LFSR)
//   n_packets     : packet limit, 0 = unlimited (latched at header entry)
//   dout_ready    : downstream accept
//   dout          : PARALLEL lanes of DOUT_WIDTH bits, lane i at [DOUT_WIDTH*i +: DOUT_WIDTH]
//   dout_valid    : beat valid
//   dout_sof      : header beat
//   dout_eof      : last beat of packet
//   pkt_count     : packets completed since reset
//   done          : packet limit reached
module pkt_stream_gen
    import pkt_stream_gen_pkg::*;
#(
    parameter int unsigned DOUT_WIDTH  = 32,
    parameter int unsigned PARALLEL    = 4,
    parameter logic [31:0] HEADER_WORD = 32'hAABBCCDD
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [31:0]                    burst_len,
    input  logic [31:0]                    sleep_write,
    input  logic [1:0]                     mode,
    input  logic [31:0]                    n_packets,
    input  logic                           dout_ready,
    output logic [DOUT_WIDTH*PARALLEL-1:0] dout,
    output logic                           dout_valid,
    output logic                           dout_sof,
    output logic                           dout_eof,
    output logic [31:0]                    pkt_count,
    output logic                           done
);

    localparam int unsigned DW = DOUT_WIDTH * PARALLEL;

    state_e      state_q, state_d;
    logic [31:0] gap_q, gap_d;
    logic [31:0] sleep_q, sleep_d;
    logic [31:0] blen_q, blen_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] npkt_q, npkt_d;
    logic [31:0] beat_q, beat_d;
    logic [31:0] base_q, base_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic [DW-1:0] dout_q, dout_d;

    logic        xfer;
    logic        hdr_entry;
    logic        burst_adv;
    logic        eop;
    logic [31:0] lane_word;

`ifdef PKT_STREAM_GEN_LFSR_EN
    logic [31:0] lfsr_val [PARALLEL];

    for (genvar g = 0; g < int'(PARALLEL); g++) begin : gen_lfsr
        lfsr32 u_lfsr (
            .clk       (clk),
            .rst       (rst),
            .load_i    (hdr_entry),
            .seed_i    (LFSR_SEED_BASE + 32'(g)),
            .advance_i (burst_adv),
            .value_o   (lfsr_val[g])
        );
    end
`endif

    assign xfer = en & valid_q & dout_ready;

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        sleep_d     = sleep_q;
        blen_d      = blen_q;
        mode_d      = mode_q;
        npkt_d      = npkt_q;
        beat_d      = beat_q;
        base_d      = base_q;
        pkt_count_d = pkt_count_q;
        done_d      = done_q;
        hdr_entry   = 1'b0;
        burst_adv   = 1'b0;
        eop         = 1'b0;

        if (en) begin
            unique case (state_q)
                StGap: begin
                    if (gap_q == sleep_q) begin
                        hdr_entry = 1'b1;
                    end else begin
                        gap_d = gap_q + 32'd1;
                    end
                end
                StHeader: begin
                    if (xfer) begin
                        if (blen_q == 32'd0) begin
                            eop = 1'b1;
                        end else begin
                            state_d = StBurst;
                            beat_d  = 32'd0;
                        end
                    end
                end
                StBurst: begin
                    if (xfer) begin
                        burst_adv = 1'b1;
                        if (beat_q == blen_q - 32'd1) begin
                            eop = 1'b1;
                        end else begin
                            beat_d = beat_q + 32'd1;
                        end
                    end
                end
                default: ;
            endcase

            if (burst_adv && (mode_q == MODE_RAMP_CONT)) begin
                base_d = base_q + 32'(PARALLEL);
            end

            if (eop) begin
                pkt_count_d = pkt_count_q + 32'd1;
                if ((npkt_q != 32'd0) && (pkt_count_d == npkt_q)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (sleep_write == 32'd0) begin
                    hdr_entry = 1'b1;
                end else begin
                    // The eof cycle itself counts as the first idle tick, so the
                    // gap between packets is exactly sleep_write invalid cycles.
                    state_d = StGap;
                    gap_d   = 32'd1;
                    sleep_d = sleep_write;
                end
            end

            if (hdr_entry) begin
                state_d = StHeader;
                gap_d   = 32'd0;
                blen_d  = burst_len;
                mode_d  = mode;
                npkt_d  = n_packets;
            end
        end

        // Outputs are derived from next state so they register alongside it.
        valid_d   = (state_d == StHeader) || (state_d == StBurst);
        sof_d     = (state_d == StHeader);
        eof_d     = ((state_d == StHeader) && (blen_d == 32'd0)) ||
                    ((state_d == StBurst) && (beat_d == blen_d - 32'd1));
        dout_d    = '0;
        lane_word = '0;
        for (int i = 0; i < int'(PARALLEL); i++) begin
            if (state_d == StHeader) begin
                if (i == 0) begin
                    lane_word = HEADER_WORD;
                end else if (i == 1) begin
                    lane_word = pkt_count_d;
                end else begin
                    lane_word = 32'd0;
                end
            end else if (state_d == StBurst) begin
                case (mode_d)
                    MODE_RAMP:      lane_word = beat_d * 32'(PARALLEL) + 32'(i);
                    MODE_RAMP_CONT: lane_word = base_d + 32'(i);
                    MODE_CONST:     lane_word = 32'(i);
                    default: begin
`ifdef PKT_STREAM_GEN_LFSR_EN
                        // Peek at the value the lane register holds after this edge.
                        lane_word = burst_adv ? lfsr_next(lfsr_val[i]) : lfsr_val[i];
`else
                        lane_word = beat_d * 32'(PARALLEL) + 32'(i);
`endif
                    end
                endcase
            end else begin
                lane_word = 32'd0;
            end
            dout_d[DOUT_WIDTH*i +: DOUT_WIDTH] = DOUT_WIDTH'(lane_word);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StGap;
            gap_q       <= 32'd0;
            sleep_q     <= sleep_write;
            blen_q      <= 32'd0;
            mode_q      <= MODE_RAMP;
            npkt_q      <= 32'd0;
            beat_q      <= 32'd0;
            base_q      <= 32'd0;
            pkt_count_q <= 32'd0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            dout_q      <= '0;
        end else if (en) begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            sleep_q     <= sleep_d;
            blen_q      <= blen_d;
            mode_q      <= mode_d;
            npkt_q      <= npkt_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            pkt_count_q <= pkt_count_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            dout_q      <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_sof   = sof_q;
    assign dout_eof   = eof_q;
    assign pkt_count  = pkt_count_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pkt_stream_gen.sv
// Self-checking bench for pkt_stream_gen. A packet-level reference model (packet index,
// beat index, ramp base) predicts each transferred beat; stimulus is randomised per test.
module tb_pkt_stream_gen;

    localparam int unsigned DW  = 32;
    localparam int unsigned P   = 4;
    localparam int unsigned W   = DW * P;
    localparam logic [31:0] HDR = 32'hAABBCCDD;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b1;
    logic [31:0]  burst_len = 32'd0;
    logic [31:0]  sleep_write = 32'd0;
    logic [1:0]   mode = 2'd0;
    logic [31:0]  n_packets = 32'd0;
    logic         dout_ready = 1'b1;
    logic [W-1:0] dout;
    logic         dout_valid, dout_sof, dout_eof, done;
    logic [31:0]  pkt_count;

    int checks = 0;
    int failures = 0;

    // Reference model state: packet index, beat index (-1 = header), config, ramp base.
    int          m_pkt;
    int          m_k;
    int          m_bl;
    logic [1:0]  m_mode;
    logic [31:0] m_base;

    pkt_stream_gen #(
        .DOUT_WIDTH  (DW),
        .PARALLEL    (P),
        .HEADER_WORD (HDR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .burst_len   (burst_len),
        .sleep_write (sleep_write),
        .mode        (mode),
        .n_packets   (n_packets),
        .dout_ready  (dout_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_sof    (dout_sof),
        .dout_eof    (dout_eof),
        .pkt_count   (pkt_count),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_ref(input logic [31:0] seed, input int steps);
        logic [31:0] s;
        s = seed;
        for (int n = 0; n < steps; n++) begin
            s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        end
        return s;
    endfunction

    function automatic logic [31:0] exp_word(input logic [1:0] md, input int k, input int i);
        logic [1:0] m;
        m = md;
`ifndef PKT_STREAM_GEN_LFSR_EN
        if (m == 2'd3) m = 2'd0;
`endif
        case (m)
            2'd0:    return 32'(k * int'(P) + i);
            2'd1:    return m_base + 32'(k * int'(P) + i);
            2'd2:    return 32'(i);
            default: return lfsr_ref(32'(1 + i), k);
        endcase
    endfunction

    function automatic logic [W-1:0] exp_beat();
        logic [W-1:0] v;
        v = '0;
        if (m_k < 0) begin
            v[31:0]  = HDR;
            v[63:32] = 32'(m_pkt);
        end else begin
            for (int i = 0; i < int'(P); i++) v[32*i +: 32] = exp_word(m_mode, m_k, i);
        end
        return v;
    endfunction

    function automatic logic exp_eof();
        return (m_k < 0) ? (m_bl == 0) : (m_k == m_bl - 1);
    endfunction

    function automatic void model_xfer();
        if (m_k < 0 && m_bl != 0) begin
            m_k = 0;
        end else if (m_k >= 0 && m_k < m_bl - 1) begin
            m_k++;
        end else begin
            if (m_mode == 2'd1) m_base += 32'(m_bl * int'(P));
            m_pkt++;
            m_k = -1;
        end
    endfunction

    task automatic do_reset(input int bl, input int s, input logic [1:0] md, input int n);
        @(negedge clk);
        rst = 1'b1; en = 1'b1; dout_ready = 1'b1;
        burst_len = 32'(bl); sleep_write = 32'(s); mode = md; n_packets = 32'(n);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_pkt = 0; m_k = -1; m_bl = bl; m_mode = md; m_base = 32'd0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; burst_len = 32'd3; sleep_write = 32'd0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dout !== '0) begin failures++; $display("FAIL reset_dout: got %h want 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
        checks++; if (dout_sof !== 1'b0 || dout_eof !== 1'b0) begin failures++; $display("FAIL reset_flags: got sof=%b eof=%b want 0 0", dout_sof, dout_eof); end
        checks++; if (pkt_count !== 32'd0) begin failures++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_basic_framing();
        int e;
        int gap;
        do_reset(3, 2, 2'd0, 0);
        e = 0;
        do begin @(negedge clk); e++; end while (!dout_valid && e < 20);
        checks++; if (e !== 3) begin failures++; $display("FAIL first_header_latency: got %0d edges want 3", e); end
        checks++; if (dout[31:0] !== HDR || dout[63:32] !== 32'd0) begin failures++; $display("FAIL first_header_lanes: got %h want lane0=%h lane1=0", dout, HDR); end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== exp_beat() || dout_sof !== 1'(b == 0) || dout_eof !== exp_eof()) begin
                failures++;
                $display("FAIL framing_beat%0d: got v=%b sof=%b eof=%b %h want sof=%b eof=%b %h", b, dout_valid, dout_sof, dout_eof, dout, b == 0, exp_eof(), exp_beat());
            end
            model_xfer();
            @(negedge clk);
        end
        gap = 0;
        while (!dout_valid && gap < 20) begin gap++; @(negedge clk); end
        checks++; if (gap !== 2) begin failures++; $display("FAIL framing_gap: got %0d idle cycles want 2", gap); end
        checks++; if (dout_sof !== 1'b1 || dout[63:32] !== 32'd1 || dout !== exp_beat()) begin failures++; $display("FAIL framing_second_header: got sof=%b %h want sof=1 %h", dout_sof, dout, exp_beat()); end
    endtask

    task automatic test_backpressure();
        logic [3:0]   pat;
        logic [W-1:0] pd;
        logic         ps, pe, stall;
        int           cyc;
        pat = 4'b1001;
        for (int r = 0; r < 3; r++) begin
            do_reset($urandom_range(1, 5), $urandom_range(0, 3), 2'($urandom_range(0, 3)), 0);
            stall = 1'b0; cyc = 0; pd = '0; ps = 1'b0; pe = 1'b0;
            while (m_pkt < 4 && cyc < 400) begin
                if (stall) begin
                    checks++;
                    if (dout_valid !== 1'b1 || dout !== pd || dout_sof !== ps || dout_eof !== pe) begin
                        failures++;
                        $display("FAIL bp_hold: got v=%b %h sof=%b eof=%b want v=1 %h sof=%b eof=%b", dout_valid, dout, dout_sof, dout_eof, pd, ps, pe);
                    end
                end
                checks++; if (pkt_count !== 32'(m_pkt)) begin failures++; $display("FAIL bp_pkt_count: got %0d want %0d", pkt_count, m_pkt); end
                dout_ready = (cyc < 24) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
                if (dout_valid && dout_ready) begin
                    checks++;
                    if (dout !== exp_beat() || dout_sof !== 1'(m_k < 0) || dout_eof !== exp_eof()) begin
                        failures++;
                        $display("FAIL bp_beat: got %h sof=%b eof=%b want %h sof=%b eof=%b", dout, dout_sof, dout_eof, exp_beat(), m_k < 0, exp_eof());
                    end
                    model_xfer();
                end
                stall = dout_valid && !dout_ready; pd = dout; ps = dout_sof; pe = dout_eof;
                cyc++;
                @(negedge clk);
            end
            checks++; if (m_pkt < 4) begin failures++; $display("FAIL bp_timeout: got %0d packets want 4", m_pkt); end
        end
        dout_ready = 1'b1;
    endtask

    task automatic test_boundaries();
        do_reset(0, 0, 2'd0, 0);
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout_sof !== 1'b1 || dout_eof !== 1'b1 || dout[63:32] !== 32'(j) || dout !== exp_beat() || pkt_count !== 32'(j)) begin
                failures++;
                $display("FAIL b2b_header%0d: got v=%b sof=%b eof=%b %h cnt=%0d want 1 1 1 %h cnt=%0d", j, dout_valid, dout_sof, dout_eof, dout, pkt_count, exp_beat(), j);
            end
            model_xfer();
            @(negedge clk);
        end
    endtask

    task automatic test_packet_limit_reset();
        int cyc;
        do_reset(2, $urandom_range(0, 2), 2'd1, 2);
        cyc = 0;
        while (!done && cyc < 100) begin
            dout_ready = 1'($urandom_range(0, 1));
            if (dout_valid && dout_ready) begin
                checks++;
                if (dout !== exp_beat() || dout_eof !== exp_eof()) begin
                    failures++;
                    $display("FAIL limit_beat: got %h eof=%b want %h eof=%b", dout, dout_eof, exp_beat(), exp_eof());
                end
                model_xfer();
            end
            cyc++;
            @(negedge clk);
        end
        checks++; if (m_base !== 32'd16) begin failures++; $display("FAIL limit_payload_span: got base %0d want 16", m_base); end
        checks++; if (pkt_count !== 32'd2 || done !== 1'b1) begin failures++; $display("FAIL limit_done: got cnt=%0d done=%b want 2 1", pkt_count, done); end
        dout_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            checks++; if (dout_valid !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL limit_idle%0d: got v=%b done=%b want 0 1", j, dout_valid, done); end
            @(negedge clk);
        end
        // Abort a packet mid-burst once a packet has completed.
        do_reset(4, 1, 2'd0, 0);
        cyc = 0;
        while (!(pkt_count == 32'd1 && dout_valid && !dout_sof) && cyc < 100) begin cyc++; @(negedge clk); end
        checks++; if (cyc >= 100) begin failures++; $display("FAIL midburst_timeout: got %0d cycles want <100", cyc); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dout !== '0 || dout_valid !== 1'b0 || dout_sof !== 1'b0 || dout_eof !== 1'b0 || pkt_count !== 32'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midburst_reset: got v=%b sof=%b eof=%b cnt=%0d done=%b %h want all 0", dout_valid, dout_sof, dout_eof, pkt_count, done, dout);
        end
        rst = 1'b0;
    endtask

    task automatic test_lfsr_enable();
        logic [W-1:0] sd;
        logic         sv, ss, se;
        logic [31:0]  sc;
        int           frz, cyc;
        logic         frz_done, was_frozen;
        do_reset(4, 1, 2'd3, 0);
        frz = 0; frz_done = 1'b0; was_frozen = 1'b0; cyc = 0;
        sd = '0; sv = 1'b0; ss = 1'b0; se = 1'b0; sc = '0;
        while (m_pkt < 3 && cyc < 200) begin
            if (was_frozen) begin
                checks++;
                if (dout !== sd || dout_valid !== sv || dout_sof !== ss || dout_eof !== se || pkt_count !== sc) begin
                    failures++;
                    $display("FAIL en_freeze: got v=%b %h cnt=%0d want v=%b %h cnt=%0d", dout_valid, dout, pkt_count, sv, sd, sc);
                end
            end
            if (!frz_done && m_pkt == 1 && m_k == 1) begin frz = 3; frz_done = 1'b1; end
            en = (frz == 0);
            if (frz > 0) frz--;
            if (en && dout_valid && dout_ready) begin
                checks++;
                if (dout !== exp_beat() || dout_sof !== 1'(m_k < 0) || dout_eof !== exp_eof()) begin
                    failures++;
                    $display("FAIL lfsr_beat: got %h sof=%b eof=%b want %h sof=%b eof=%b", dout, dout_sof, dout_eof, exp_beat(), m_k < 0, exp_eof());
                end
                model_xfer();
            end
            was_frozen = !en; sd = dout; sv = dout_valid; ss = dout_sof; se = dout_eof; sc = pkt_count;
            cyc++;
            @(negedge clk);
        end
        en = 1'b1;
        checks++; if (m_pkt < 3 || !frz_done) begin failures++; $display("FAIL lfsr_timeout: got %0d packets want 3", m_pkt); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_framing();
        test_backpressure();
        test_boundaries();
        test_packet_limit_reset();
        test_lfsr_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pkt_stream_gen.md
# pkt_stream_gen

Parametrised test-pattern packet source for the gbe write packetizer test module. Emits framed packets of `PARALLEL` lanes × `DOUT_WIDTH` bits: a header beat followed by `burst_len` payload beats, separated by `sleep_write` idle cycles. Extends the fixed counter generator with:
- a ready/valid handshake (backpressure);
- start/end-of-frame flags;
- selectable payload modes;
- a packet-count limit with a done flag.

It sits upstream of the packetizer, driven from software registers.

## Interface
Parameters:
- `DOUT_WIDTH`, 32: bits per lane.
- `PARALLEL`, 4: lanes per beat.
- `HEADER_WORD`, 32'hAABBCCDD: marker placed on lane 0 of every header beat. It is truncated to `DOUT_WIDTH`.

Ports (clock and reset first):
- `clk` (in, 1): the single clock.
- `rst` (in, 1): reset, synchronous and active-high.
- `en` (in, 1): global advance enable. When low, all state freezes and no beat transfers.
- `burst_len` (in, 32): payload beats per packet.
- `sleep_write` (in, 32): idle cycles between packets.
- `mode` (in, 2): payload pattern.
  - 0: ramp that restarts each packet.
  - 1: continuous ramp.
  - 2: constant.
  - 3: LFSR.
- `n_packets` (in, 32): packets to send. 0 means unlimited.
- `dout_ready` (in, 1): downstream accept.
- `dout` (out, `DOUT_WIDTH*PARALLEL`): lane i occupies bits `[DOUT_WIDTH*i +: DOUT_WIDTH]`.
- `dout_valid` (out, 1): beat valid.
- `dout_sof` (out, 1): asserted on the header beat.
- `dout_eof` (out, 1): asserted on the last beat of the packet.
- `pkt_count` (out, 32): packets completed since reset.
- `done` (out, 1): the `n_packets` limit has been reached.

## Operation
- A beat transfers on a rising edge where `en & dout_valid & dout_ready` all hold.
- While `dout_valid=1` and the beat has not transferred, `dout`, `dout_sof` and `dout_eof` hold stable.
- All outputs are registered. Reset values: `dout=0`, `dout_valid=0`, `dout_sof=0`, `dout_eof=0`, `pkt_count=0`, `done=0`, state GAP, gap counter 0, ramp base 0.

States:
- **GAP**
  - The gap counter increments on each enabled cycle.
  - When it equals the latched `sleep_write`, the block goes to HEADER and asserts valid on that same edge.
  - With `sleep_write=0`, HEADER follows immediately.
- **HEADER**
  - Beat contents: lane 0 = `HEADER_WORD`; lane 1 = `pkt_count`, truncated; other lanes = 0. `sof=1`.
  - `burst_len`, `mode` and `n_packets` are latched on entry, so changes mid-packet take effect at the next packet.
  - On transfer: go to BURST. If `burst_len=0`, the header beat also carries `eof=1` and the packet ends on its transfer.
- **BURST**
  - Emits `burst_len` beats; the last one carries `eof=1`.
  - Beat k, lane i, by mode:
    - mode 0: `k*PARALLEL+i`.
    - mode 1: `base+k*PARALLEL+i`. `base` persists across packets and advances by `PARALLEL` per beat.
    - mode 2: `i`.
    - mode 3: LFSR output of lane i.
  - Arithmetic is 32-bit with wrap-around, truncated to `DOUT_WIDTH`.
- **End of packet** (transfer of the eof beat):
  - `pkt_count` increments and wraps at 2^32.
  - If `n_packets≠0` and the new count equals `n_packets`, go to DONE and set `done=1`.
  - Otherwise go to GAP with the counter cleared. If `sleep_write=0`, go directly to HEADER with valid remaining high (back-to-back packets).
- **DONE**
  - `dout_valid=0`. Left only by `rst`.
- **Reset mid-operation**
  - `rst` aborts any packet. The next cycle shows all reset values; no eof is emitted for the aborted packet.

## Timing
- After `rst` deasserts with `en=1` held and `sleep_write=S`, the header is valid after the (S+1)th edge.
- With `dout_ready=1` held, each beat lasts exactly one cycle.
- A packet occupies `1+burst_len` beats plus S idle cycles.
- An `en` low cycle stretches every phase by one cycle and never drops or duplicates a beat.

## Configuration
- Macro `PKT_STREAM_GEN_LFSR_EN`.
- **Defined:** mode 3 uses per-lane 32-bit Galois LFSRs.
  - Polynomial x^32+x^22+x^2+x+1.
  - Lane i seed: `32'h1+i`.
  - Reseeded at HEADER entry; advanced once per transferred BURST beat.
- **Undefined:** no LFSR logic is built, and mode 3 behaves as mode 0.

## Structure
- Package `pkt_stream_gen_pkg` holds:
  - the state enum (GAP, HEADER, BURST, DONE);
  - mode constants `MODE_RAMP`, `MODE_RAMP_CONT`, `MODE_CONST`, `MODE_LFSR`;
  - the LFSR polynomial and seed constants.
- Sub-module `lfsr32` has ports: clock, reset, load, seed, advance, value. It is instantiated `PARALLEL` times under the macro.

## Test plan
- **Basic framing.** Stimulus: `burst_len=3`, `sleep_write=2`, mode 0, `ready=1`, `PARALLEL=4`. Required response:
  - header beat: lane0=AABBCCDD, lane1=0, `sof=1`;
  - payload beats: {0,1,2,3}, {4,5,6,7}, {8,9,10,11}, the last with `eof=1`;
  - exactly 2 invalid cycles, then the next header with lane1=1.
- **Backpressure.** Stimulus: `dout_ready` toggles 1,0,0,1 during BURST. Required response: data stays stable through the low cycles; no beat is lost or repeated; `pkt_count` increments only on eof transfer.
- **Boundaries.** Stimulus: `burst_len=0`, `sleep_write=0`. Required response: continuous header-only beats, each with `sof=eof=1`, with lane1 counting 0,1,2,… back-to-back.
- **Packet limit and reset.** Stimulus: `n_packets=2`, mode 1, `burst_len=2`. Required response:
  - packet 0 payload values 0..7; packet 1 payload values 8..15;
  - then `done=1` and `valid` stays 0;
  - `rst` mid-BURST returns all outputs to reset values on the next cycle.
- **LFSR and enable freeze.** Stimulus: mode 3 with the macro defined, then `en=0` for 3 cycles mid-burst. Required response:
  - lane 0's first payload word matches a reference model seeded with 1, and the same sequence repeats in every packet;
  - with the macro undefined, mode 3 output equals mode 0 output;
  - the `en=0` gap freezes outputs and counters unchanged.
